// File: rtl/game_pkg.sv
// Shared game constants: direction indices, FSM encoding, map geometry, wall tile id.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package game_pkg;

    // Button bit indices into btn_n; also used directly as the 2-bit move direction code.
    localparam logic [1:0] DIR_UP = 2'd0;
    localparam logic [1:0] DIR_DN = 2'd1;
    localparam logic [1:0] DIR_LT = 2'd2;
    localparam logic [1:0] DIR_RT = 2'd3;

    // Map geometry and blocking tile, shared with render_map and the top level.
    localparam int          MAP_W_DEF   = 11;
    localparam int          MAP_H_DEF   = 11;
    localparam logic [15:0] WALL_ID_DEF = 16'h0002;

    localparam int ADDR_W = 19;
    localparam int POS_W  = 4;
    localparam int TILE_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_WAIT = 2'd2
    } move_state_t;

endpackage

// File: rtl/btn_press_repeat.sv
// Button press detector: edge detect on active-low buttons, priority encode, optional hold-repeat.
// Latency: press/dir registered one edge after the button is first seen low.
// Backpressure: none; press is a 1-cycle pulse and the consumer drops it if it cannot take it.
//
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   btn_n[3:0]  debounced buttons, low = pressed ([0]=up [1]=down [2]=left [3]=right)
//   press       1-cycle pulse per accepted press or repeat
//   dir[1:0]    direction code of the press (valid with press)
module btn_press_repeat
    import game_pkg::*;
#(
    parameter int REPEAT_CYC = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn_n,
    output logic       press,
    output logic [1:0] dir
);

    localparam int CNT_W = (REPEAT_CYC > 1) ? $clog2(REPEAT_CYC) : 1;

    logic [3:0]       prev_n;
    logic [3:0]       edge_vec;
    logic             any_edge;
    logic [1:0]       win_dir;
    logic             hold_vld;
    logic [1:0]       hold_dir;
    logic [CNT_W-1:0] rep_cnt;

    // A press is a button low now that was high last cycle.
    assign edge_vec = ~btn_n & prev_n;
    assign any_edge = |edge_vec;

    always_comb begin
        win_dir = DIR_UP;
        if (edge_vec[DIR_UP])      win_dir = DIR_UP;
        else if (edge_vec[DIR_DN]) win_dir = DIR_DN;
        else if (edge_vec[DIR_LT]) win_dir = DIR_LT;
        else if (edge_vec[DIR_RT]) win_dir = DIR_RT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // "All pressed" so a button held through reset never counts as a fresh press.
            prev_n   <= 4'b0000;
            press    <= 1'b0;
            dir      <= DIR_UP;
            hold_vld <= 1'b0;
            hold_dir <= DIR_UP;
            rep_cnt  <= '0;
        end else begin
            prev_n <= btn_n;
            press  <= 1'b0;
            if (any_edge) begin
                press    <= 1'b1;
                dir      <= win_dir;
                hold_vld <= 1'b1;
                hold_dir <= win_dir;
                rep_cnt  <= '0;
            end else if (hold_vld && !btn_n[hold_dir]) begin
                // Winning button still held: inject a press every REPEAT_CYC cycles.
                if (REPEAT_CYC > 0) begin
                    if (rep_cnt == CNT_W'(REPEAT_CYC - 1)) begin
                        press   <= 1'b1;
                        dir     <= hold_dir;
                        rep_cnt <= '0;
                    end else begin
                        rep_cnt <= rep_cnt + 1'b1;
                    end
                end
            end else begin
                hold_vld <= 1'b0;
                rep_cnt  <= '0;
            end
        end
    end

endmodule

// File: rtl/player_move_ctrl.sv
// Player movement controller: single-tile steps checked against map bounds and map BRAM walls.
// Latency: map_rd one edge after press detect; move/bump resolves RD_LAT edges later (OOB bump: one edge).
// Backpressure: none; presses arriving while busy are dropped, not queued.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   btn_n[3:0]        debounced buttons, low = pressed ([0]=up [1]=down [2]=left [3]=right)
//   map_addr[18:0]    registered map read address (y*MAP_W + x)
//   map_rd            1-cycle strobe in the cycle map_addr is presented
//   map_tile_id[15:0] map read data, sampled RD_LAT edges after map_rd rises
//   pos_x, pos_y      registered player grid position
//   moved, bumped     1-cycle result pulses (never together)
//   busy              high while a map read is outstanding
module player_move_ctrl
    import game_pkg::*;
#(
    parameter int          MAP_W      = MAP_W_DEF,
    parameter int          MAP_H      = MAP_H_DEF,
    parameter int          START_X    = 1,
    parameter int          START_Y    = 1,
    parameter logic [15:0] WALL_ID    = WALL_ID_DEF,
    parameter int          RD_LAT     = 1,
    parameter int          REPEAT_CYC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        btn_n,
    output logic [ADDR_W-1:0] map_addr,
    output logic              map_rd,
    input  logic [TILE_W-1:0] map_tile_id,
    output logic [POS_W-1:0]  pos_x,
    output logic [POS_W-1:0]  pos_y,
    output logic              moved,
    output logic              bumped,
    output logic              busy
);

    localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic signed [4:0] MAP_W_S = 5'(MAP_W);
    localparam logic signed [4:0] MAP_H_S = 5'(MAP_H);

    logic        press;
    logic [1:0]  dir;

    move_state_t state_q, state_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic [POS_W-1:0] tgt_x_q, tgt_x_d, tgt_y_q, tgt_y_d;
    logic [POS_W-1:0] pos_x_d, pos_y_d;
    logic [ADDR_W-1:0] map_addr_d;
    logic map_rd_d, moved_d, bumped_d, busy_d;

    logic signed [4:0] tx, ty;
    logic              oob;
    logic [ADDR_W-1:0] tgt_addr;

    btn_press_repeat #(
        .REPEAT_CYC (REPEAT_CYC)
    ) u_btn (
        .clk   (clk),
        .rst   (rst),
        .btn_n (btn_n),
        .press (press),
        .dir   (dir)
    );

    // Target one step away, in 5-bit signed so a step off the low edge shows up as negative.
    always_comb begin
        tx = $signed({1'b0, pos_x});
        ty = $signed({1'b0, pos_y});
        case (dir)
            DIR_UP:  ty = ty - 5'sd1;
            DIR_DN:  ty = ty + 5'sd1;
            DIR_LT:  tx = tx - 5'sd1;
            default: tx = tx + 5'sd1;
        endcase
    end

    assign oob = tx[4] || ty[4] || (tx >= MAP_W_S) || (ty >= MAP_H_S);

    // Only consumed when in bounds, so the low 4 bits are the true non-negative coordinates.
    assign tgt_addr = ADDR_W'(ty[3:0]) * ADDR_W'(MAP_W) + ADDR_W'(tx[3:0]);

    always_comb begin
        state_d    = state_q;
        lat_d      = lat_q;
        tgt_x_d    = tgt_x_q;
        tgt_y_d    = tgt_y_q;
        pos_x_d    = pos_x;
        pos_y_d    = pos_y;
        map_addr_d = map_addr;
        map_rd_d   = 1'b0;
        moved_d    = 1'b0;
        bumped_d   = 1'b0;
        busy_d     = busy;
        case (state_q)
            ST_IDLE: begin
                if (press) begin
                    if (oob) begin
                        bumped_d = 1'b1;
                    end else begin
                        map_addr_d = tgt_addr;
                        map_rd_d   = 1'b1;
                        busy_d     = 1'b1;
                        tgt_x_d    = tx[3:0];
                        tgt_y_d    = ty[3:0];
                        lat_d      = LAT_W'(RD_LAT - 1);
                        state_d    = ST_READ;
                    end
                end
            end
            ST_READ, ST_WAIT: begin
                // lat_q counts the remaining edges until read data is valid.
                if (lat_q == '0) begin
                    if (map_tile_id == WALL_ID) begin
                        bumped_d = 1'b1;
                    end else begin
                        pos_x_d = tgt_x_q;
                        pos_y_d = tgt_y_q;
                        moved_d = 1'b1;
                    end
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    lat_d   = lat_q - 1'b1;
                    state_d = ST_WAIT;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            lat_q    <= '0;
            tgt_x_q  <= '0;
            tgt_y_q  <= '0;
            pos_x    <= POS_W'(START_X);
            pos_y    <= POS_W'(START_Y);
            map_addr <= '0;
            map_rd   <= 1'b0;
            moved    <= 1'b0;
            bumped   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_d;
            lat_q    <= lat_d;
            tgt_x_q  <= tgt_x_d;
            tgt_y_q  <= tgt_y_d;
            pos_x    <= pos_x_d;
            pos_y    <= pos_y_d;
            map_addr <= map_addr_d;
            map_rd   <= map_rd_d;
            moved    <= moved_d;
            bumped   <= bumped_d;
            busy     <= busy_d;
        end
    end

endmodule

// File: tb/tb_player_move_ctrl.sv
module tb_player_move_ctrl;

    localparam logic [3:0] B_NONE = 4'b1111;
    localparam logic [3:0] B_UP   = 4'b1110;
    localparam logic [3:0] B_DN   = 4'b1101;
    localparam logic [3:0] B_LT   = 4'b1011;
    localparam logic [3:0] B_RT   = 4'b0111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [3:0]  btn_a, btn_b;
    logic [18:0] addr_a, addr_b;
    logic        rd_a, rd_b;
    logic [15:0] tile_a, tile_b;
    logic [3:0]  px_a, py_a, px_b, py_b;
    logic        mv_a, bp_a, bz_a, mv_b, bp_b, bz_b;

    player_move_ctrl #(.RD_LAT(1), .REPEAT_CYC(8)) dut_a (
        .clk(clk), .rst(rst), .btn_n(btn_a), .map_addr(addr_a), .map_rd(rd_a),
        .map_tile_id(tile_a), .pos_x(px_a), .pos_y(py_a), .moved(mv_a),
        .bumped(bp_a), .busy(bz_a)
    );

    player_move_ctrl #(.RD_LAT(3), .REPEAT_CYC(0)) dut_b (
        .clk(clk), .rst(rst), .btn_n(btn_b), .map_addr(addr_b), .map_rd(rd_b),
        .map_tile_id(tile_b), .pos_x(px_b), .pos_y(py_b), .moved(mv_b),
        .bumped(bp_b), .busy(bz_b)
    );

    // Map: walls at (1,0)=addr 1 and (10,9)=addr 109, everything else open.
    function automatic logic [15:0] tile_at(input logic [18:0] a);
        if (a == 19'd1 || a == 19'd109) return 16'h0002;
        return 16'h0000;
    endfunction

    // Read data is only meaningful in its latency window; outside it the bus reads as a wall.
    assign tile_a = rd_a ? tile_at(addr_a) : 16'h0002;

    logic [15:0] pipe_b0 = 16'h0002;
    logic [15:0] pipe_b1 = 16'h0002;
    always @(posedge clk) begin
        pipe_b0 <= rd_b ? tile_at(addr_b) : 16'h0002;
        pipe_b1 <= pipe_b0;
    end
    assign tile_b = pipe_b1;

    int n_tests = 0;
    int n_fail  = 0;
    int cur_idx = -1;
    bit mon_en  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (vec %0d): got %0h, expected %0h", name, cur_idx, act, exp);
        end
    endtask

    // One clock edge, then settle; results reflect that edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (mon_en) begin
            chk("excl_a", 32'(mv_a & bp_a), 32'd0);
            chk("excl_b", 32'(mv_b & bp_b), 32'd0);
        end
    endtask

    typedef struct {
        logic [3:0]  btn;
        logic        exp_rd;
        logic [18:0] exp_addr;
        logic        exp_mv;
        logic        exp_bp;
        logic [3:0]  exp_x;
        logic [3:0]  exp_y;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic [3:0] b, input logic rd, input int addr,
                           input logic mv, input logic bp, input int x, input int y);
        vec_t v;
        v.btn = b; v.exp_rd = rd; v.exp_addr = 19'(addr);
        v.exp_mv = mv; v.exp_bp = bp; v.exp_x = 4'(x); v.exp_y = 4'(y);
        vecs.push_back(v);
    endtask

    initial begin
        int ev;
        vec_t v;

        // Walk from (1,1) to the corners of the map.
        add_vec(B_UP, 1, 1,  0, 1, 1, 1);   // wall above start
        add_vec(B_RT, 1, 13, 1, 0, 2, 1);
        add_vec(B_LT, 1, 12, 1, 0, 1, 1);
        add_vec(B_LT, 1, 11, 1, 0, 0, 1);
        add_vec(B_UP, 1, 0,  1, 0, 0, 0);
        add_vec(B_LT, 0, 0,  0, 1, 0, 0);   // off left edge
        add_vec(B_UP, 0, 0,  0, 1, 0, 0);   // off top edge
        for (int y = 1; y <= 10; y++) add_vec(B_DN, 1, y * 11, 1, 0, 0, y);
        for (int x = 1; x <= 10; x++) add_vec(B_RT, 1, 110 + x, 1, 0, x, 10);
        add_vec(B_DN, 0, 0,   0, 1, 10, 10); // off bottom edge
        add_vec(B_RT, 0, 0,   0, 1, 10, 10); // off right edge
        add_vec(B_UP, 1, 109, 0, 1, 10, 10); // wall at (10,9)

        // Reset with up held: nothing may happen afterwards.
        rst = 1'b1; btn_a = B_UP; btn_b = B_NONE;
        repeat (3) tick();
        chk("rst_pos_x", 32'(px_a), 32'd1);
        chk("rst_pos_y", 32'(py_a), 32'd1);
        chk("rst_addr",  32'(addr_a), 32'd0);
        chk("rst_rd",    32'(rd_a), 32'd0);
        chk("rst_flags", 32'({mv_a, bp_a, bz_a}), 32'd0);
        chk("rst_b_pos", 32'({px_b, py_b}), 32'h11);
        rst = 1'b0; mon_en = 1'b1;
        ev = 0;
        repeat (20) begin
            tick();
            ev += int'(mv_a) + int'(bp_a) + int'(rd_a);
        end
        chk("held_thru_rst_events", 32'(ev), 32'd0);
        chk("held_thru_rst_pos", 32'({px_a, py_a}), 32'h11);
        btn_a = B_NONE;
        repeat (2) tick();

        // Table-driven single moves on dut_a (RD_LAT=1).
        for (int i = 0; i < vecs.size(); i++) begin
            cur_idx = i;
            v = vecs[i];
            btn_a = v.btn;
            tick();                        // press detected
            chk("n_rd", 32'(rd_a), 32'd0);
            chk("n_result", 32'({mv_a, bp_a}), 32'd0);
            btn_a = B_NONE;
            tick();                        // issue or OOB bump
            chk("rd", 32'(rd_a), 32'(v.exp_rd));
            chk("busy", 32'(bz_a), 32'(v.exp_rd));
            if (v.exp_rd) begin
                chk("addr", 32'(addr_a), 32'(v.exp_addr));
                chk("early_result", 32'({mv_a, bp_a}), 32'd0);
                tick();                    // read resolves
                chk("rd_pulse", 32'(rd_a), 32'd0);
                chk("busy_fall", 32'(bz_a), 32'd0);
            end
            chk("moved", 32'(mv_a), 32'(v.exp_mv));
            chk("bumped", 32'(bp_a), 32'(v.exp_bp));
            chk("pos", 32'({px_a, py_a}), 32'({v.exp_x, v.exp_y}));
            tick();
        end
        cur_idx = -1;

        // dut_b (RD_LAT=3): up+right together, then a press during busy.
        btn_b = 4'b0110;
        tick();
        chk("b_n_rd", 32'(rd_b), 32'd0);
        tick();
        chk("b_rd", 32'(rd_b), 32'd1);
        chk("b_addr_up", 32'(addr_b), 32'd1);
        chk("b_busy1", 32'(bz_b), 32'd1);
        btn_b = 4'b0100;                   // down pressed while busy
        tick();
        chk("b_busy2", 32'({bz_b, mv_b, bp_b}), 32'b100);
        tick();
        chk("b_busy3", 32'({bz_b, mv_b, bp_b, rd_b}), 32'b1000);
        tick();
        chk("b_bump", 32'({bz_b, mv_b, bp_b}), 32'b001);
        chk("b_pos", 32'({px_b, py_b}), 32'h11);
        ev = 0;
        repeat (10) begin
            tick();
            ev += int'(rd_b) + int'(mv_b) + int'(bp_b);
        end
        chk("b_dropped_press", 32'(ev), 32'd0);
        btn_b = B_NONE;
        repeat (2) tick();
        btn_b = B_RT;
        tick();
        btn_b = B_NONE;
        tick();
        chk("b2_rd", 32'({rd_b, bz_b}), 32'b11);
        chk("b2_addr", 32'(addr_b), 32'd13);
        ev = 1;
        repeat (2) begin
            tick();
            chk("b2_no_result", 32'({mv_b, bp_b}), 32'd0);
            ev += int'(bz_b);
        end
        tick();
        chk("b2_busy_cycles", 32'(ev), 32'd3);
        chk("b2_moved", 32'({mv_b, bz_b}), 32'b10);
        chk("b2_pos", 32'({px_b, py_b}), 32'h21);

        // Hold-repeat on dut_a: right held 40 cycles along row 1.
        rst = 1'b1; btn_a = B_NONE; btn_b = B_NONE;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        btn_a = B_RT;
        ev = 0;
        repeat (40) begin
            tick();
            ev += int'(mv_a) + 100 * int'(bp_a);
        end
        btn_a = B_NONE;
        repeat (10) begin
            tick();
            ev += int'(mv_a) + 100 * int'(bp_a);
        end
        chk("rep_moves", 32'(ev), 32'd5);
        chk("rep_pos", 32'({px_a, py_a}), 32'h61);

        // Reset during dut_b's WAIT aborts the move.
        btn_b = B_RT;
        tick();
        btn_b = B_NONE;
        tick();
        chk("abort_rd", 32'(rd_b), 32'd1);
        tick();
        chk("abort_busy", 32'({bz_b, mv_b}), 32'b10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_pos", 32'({px_b, py_b}), 32'h11);
        chk("abort_busy0", 32'(bz_b), 32'd0);
        ev = 0;
        repeat (10) begin
            tick();
            ev += int'(mv_b) + int'(bp_b) + int'(bz_b);
        end
        chk("abort_no_move", 32'(ev), 32'd0);
        chk("abort_pos_end", 32'({px_b, py_b}), 32'h11);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
